// File: rtl/riscv_pkg.sv
// Shared RV32I definitions used by fetch and decode: opcodes, the canonical NOP,
// and the fetch-stage state and slot types.
package riscv_pkg;

   localparam logic [31:0] NOP_INST = 32'h0000_0013;   // addi x0,x0,0

   localparam logic [6:0] OP_IMM = 7'b0010011;
   localparam logic [6:0] LUI    = 7'b0110111;
   localparam logic [6:0] AUIPC  = 7'b0010111;
   localparam logic [6:0] OP     = 7'b0110011;
   localparam logic [6:0] JAL    = 7'b1101111;
   localparam logic [6:0] JALR   = 7'b1100111;
   localparam logic [6:0] BRANCH = 7'b1100011;
   localparam logic [6:0] LOAD   = 7'b0000011;
   localparam logic [6:0] STORE  = 7'b0100011;

   typedef enum logic {
      FETCH = 1'b0,
      DRAIN = 1'b1
   } fetch_state_t;

   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] pc;
   } fetch_slot_t;

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_skid.sv
// One-entry holding buffer for a fetched {inst, pc} pair that the decoder could
// not take yet.
module fetch_skid
   import riscv_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        load,
   input  logic        unload,
   input  logic        flush,
   input  fetch_slot_t din,
   output fetch_slot_t dout,
   output logic        valid
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid <= 1'b0;
      end else if (flush) begin
         valid <= 1'b0;
      end else if (load) begin
         valid <= 1'b1;
      end else if (unload) begin
         valid <= 1'b0;
      end
   end

   // NOTE: the payload is only ever read while valid is set, so it carries no reset.
   always_ff @(posedge clk) begin
      if (load && !flush) begin
         dout <= din;
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// RV32I instruction fetch: owns the PC, handshakes with instruction memory and
// hands one {instruction, pc} per cycle to the decoder, with skid and redirect.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic [31:0] instruccion,
   output logic [31:0] pc_out,
   output logic        inst_valid,
   output logic        misaligned_err
);

   import riscv_pkg::*;

   fetch_state_t state, state_nxt;
   logic [31:0]  pc, pc_nxt;
   logic [31:0]  pending_pc, pending_pc_nxt;
   logic [31:0]  target;

   logic         consume;
   logic         accept;
   logic         skid_valid;
   logic         skid_load;
   logic         skid_unload;
   fetch_slot_t  skid_din;
   fetch_slot_t  skid_dout;

   assign target    = word_align(redirect_pc);
   assign imem_addr = pc;

   // A pending request keeps req high; a full skid is the only thing that drops it.
   assign imem_req = !reset && ((state == DRAIN) || !skid_valid);

   assign consume     = inst_valid && !stall;
   assign accept      = imem_req && imem_ack && !redirect && (state == FETCH);
   assign skid_load   = accept && inst_valid && !consume;
   assign skid_unload = consume && skid_valid;
   assign skid_din    = '{inst: imem_rdata, pc: pc};

   fetch_skid u_skid (
      .clk    (clk),
      .reset  (reset),
      .load   (skid_load),
      .unload (skid_unload),
      .flush  (redirect),
      .din    (skid_din),
      .dout   (skid_dout),
      .valid  (skid_valid)
   );

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      state_nxt      = state;
      pc_nxt         = pc;
      pending_pc_nxt = pending_pc;

      if (redirect) begin
         if (imem_req && !imem_ack) begin
            // The old request must still complete; remember where to go afterwards.
            state_nxt      = DRAIN;
            pending_pc_nxt = target;
         end else begin
            state_nxt = FETCH;
            pc_nxt    = target;
         end
      end else if (state == DRAIN) begin
         if (imem_ack) begin
            state_nxt = FETCH;
            pc_nxt    = pending_pc;
         end
      end else if (accept) begin
         pc_nxt = pc + 32'd4;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      // NOTE: all state uses non-blocking assignment so every flop sees pre-edge values.
      if (reset) begin
         state      <= FETCH;
         pc         <= RESET_PC;
         pending_pc <= RESET_PC;
      end else begin
         state      <= state_nxt;
         pc         <= pc_nxt;
         pending_pc <= pending_pc_nxt;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         instruccion    <= NOP_INST;
         pc_out         <= '0;
         inst_valid     <= 1'b0;
         misaligned_err <= 1'b0;
      end else begin
         misaligned_err <= redirect && (redirect_pc[1:0] != 2'b00);

         if (redirect) begin
            inst_valid  <= 1'b0;
            instruccion <= NOP_INST;
         end else if (accept && (!inst_valid || consume)) begin
            instruccion <= imem_rdata;
            pc_out      <= pc;
            inst_valid  <= 1'b1;
         end else if (skid_unload) begin
            instruccion <= skid_dout.inst;
            pc_out      <= skid_dout.pc;
            inst_valid  <= 1'b1;
         end else if (consume) begin
            inst_valid  <= 1'b0;
            instruccion <= NOP_INST;
         end
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a queue-based model of the fetch stage checked every
// cycle, plus directed scenarios pinned with literal expectations.
module tb_fetch_unit;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] NOP_INST = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        reset;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic [31:0] instruccion;
   logic [31:0] pc_out;
   logic        inst_valid;
   logic        misaligned_err;

   int n_checks = 0;
   int n_pass   = 0;

   fetch_unit #(
      .RESET_PC (RESET_PC),
      .NOP_INST (NOP_INST)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_ack       (imem_ack),
      .imem_rdata     (imem_rdata),
      .stall          (stall),
      .redirect       (redirect),
      .redirect_pc    (redirect_pc),
      .instruccion    (instruccion),
      .pc_out         (pc_out),
      .inst_valid     (inst_valid),
      .misaligned_err (misaligned_err)
   );

   always #5 clk = ~clk;

   // Memory returns a word derived from its address so order and pc pairing are visible.
   assign imem_rdata = imem_addr + 32'h100;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Model: fetched-but-unconsumed instructions form a queue of depth two.
   typedef struct {
      logic [31:0] inst;
      logic [31:0] pc;
   } entry_t;

   entry_t      m_q[$];
   logic [31:0] m_addr  = RESET_PC;
   logic [31:0] m_pend  = RESET_PC;
   logic        m_drain = 1'b0;
   logic        m_mis   = 1'b0;
   logic        m_req_now;
   logic [31:0] m_tgt;

   initial forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
         m_q.delete();
         m_addr  = RESET_PC;
         m_pend  = RESET_PC;
         m_drain = 1'b0;
         m_mis   = 1'b0;
      end else begin
         m_req_now = m_drain || (m_q.size() < 2);
         m_tgt     = {redirect_pc[31:2], 2'b00};
         m_mis     = redirect && (redirect_pc[1:0] != 2'b00);
         if (redirect) begin
            m_q.delete();
            if (m_req_now && !imem_ack) begin
               m_drain = 1'b1;
               m_pend  = m_tgt;
            end else begin
               m_drain = 1'b0;
               m_addr  = m_tgt;
            end
         end else begin
            if (m_q.size() > 0 && !stall) void'(m_q.pop_front());
            if (m_drain) begin
               if (imem_ack) begin
                  m_drain = 1'b0;
                  m_addr  = m_pend;
               end
            end else if (m_req_now && imem_ack) begin
               m_q.push_back('{inst: m_addr + 32'h100, pc: m_addr});
               m_addr = m_addr + 32'd4;
            end
         end
      end
   end

   always @(negedge clk) begin
      check("imem_req", 32'(imem_req), 32'(!reset && (m_drain || (m_q.size() < 2))));
      check("imem_addr", imem_addr, m_addr);
      check("inst_valid", 32'(inst_valid), (m_q.size() > 0) ? 32'd1 : 32'd0);
      if (m_q.size() > 0) begin
         check("instruccion", instruccion, m_q[0].inst);
         check("pc_out", pc_out, m_q[0].pc);
      end else begin
         check("instruccion_nop", instruccion, NOP_INST);
      end
      check("misaligned_err", 32'(misaligned_err), 32'(m_mis));
   end

   logic [39:0] stall_pat = 40'h00_F0_3C_0E_70;
   logic [39:0] ack_pat   = 40'hFF_7B_DE_F7_3F;
   logic [39:0] redir_pat = 40'h04_00_80_10_02;

   initial begin
      reset       = 1'b1;
      imem_ack    = 1'b0;
      stall       = 1'b0;
      redirect    = 1'b0;
      redirect_pc = '0;
      repeat (2) step();

      check("rst_req", 32'(imem_req), 32'd0);
      check("rst_addr", imem_addr, RESET_PC);
      check("rst_inst", instruccion, NOP_INST);
      check("rst_pc_out", pc_out, 32'd0);
      check("rst_valid", 32'(inst_valid), 32'd0);
      check("rst_mis", 32'(misaligned_err), 32'd0);

      // Streaming from reset with ack every cycle
      reset    = 1'b0;
      imem_ack = 1'b1;
      check("pre_valid", 32'(inst_valid), 32'd0);
      check("pre_inst", instruccion, NOP_INST);
      for (int i = 0; i < 4; i++) begin
         step();
         check("str_valid", 32'(inst_valid), 32'd1);
         check("str_inst", instruccion, 32'h100 + 32'(i) * 4);
         check("str_pc", pc_out, 32'(i) * 4);
      end

      // Stall for three cycles straight out of reset
      reset = 1'b1;
      step();
      reset = 1'b0;
      stall = 1'b1;
      step();
      check("stl_inst0", instruccion, 32'h100);
      step();
      check("stl_req_low", 32'(imem_req), 32'd0);
      step();
      check("stl_req_low2", 32'(imem_req), 32'd0);
      check("stl_hold", instruccion, 32'h100);
      stall = 1'b0;
      step();
      check("stl_inst1", instruccion, 32'h104);
      check("stl_pc1", pc_out, 32'h4);
      step();
      check("stl_inst2", instruccion, 32'h108);
      check("stl_pc2", pc_out, 32'h8);
      step();
      check("stl_inst3", instruccion, 32'h10c);

      // Redirect with an ack in the same cycle
      redirect    = 1'b1;
      redirect_pc = 32'h40;
      step();
      redirect = 1'b0;
      check("rdA_valid", 32'(inst_valid), 32'd0);
      check("rdA_inst", instruccion, NOP_INST);
      check("rdA_addr", imem_addr, 32'h40);
      step();
      check("rdA_inst2", instruccion, 32'h140);
      check("rdA_pc2", pc_out, 32'h40);

      // Redirect while a request waits three cycles for its ack
      imem_ack    = 1'b0;
      redirect    = 1'b1;
      redirect_pc = 32'h80;
      step();
      redirect = 1'b0;
      check("drn_req", 32'(imem_req), 32'd1);
      check("drn_addr", imem_addr, 32'h44);
      check("drn_valid", 32'(inst_valid), 32'd0);
      repeat (2) step();
      check("drn_addr_held", imem_addr, 32'h44);
      imem_ack = 1'b1;
      step();
      check("drn_dropped", 32'(inst_valid), 32'd0);
      check("drn_target", imem_addr, 32'h80);
      step();
      check("drn_inst", instruccion, 32'h180);
      check("drn_pc", pc_out, 32'h80);

      // Misaligned redirect target
      redirect    = 1'b1;
      redirect_pc = 32'h1002;
      step();
      redirect = 1'b0;
      check("mis_pulse", 32'(misaligned_err), 32'd1);
      check("mis_addr", imem_addr, 32'h1000);
      step();
      check("mis_clear", 32'(misaligned_err), 32'd0);
      check("mis_inst", instruccion, 32'h1100);
      check("mis_pc", pc_out, 32'h1000);

      // Reset asserted while draining
      imem_ack    = 1'b0;
      redirect    = 1'b1;
      redirect_pc = 32'h200;
      step();
      redirect = 1'b0;
      check("rdr_addr", imem_addr, 32'h1004);
      #2;
      reset = 1'b1;
      #1;
      check("rdr_req", 32'(imem_req), 32'd0);
      check("rdr_valid", 32'(inst_valid), 32'd0);
      check("rdr_addr_rst", imem_addr, RESET_PC);
      check("rdr_inst", instruccion, NOP_INST);
      step();
      reset    = 1'b0;
      imem_ack = 1'b1;
      step();
      check("rdr_restart_inst", instruccion, 32'h100);
      check("rdr_restart_pc", pc_out, RESET_PC);

      // Mixed stall / ack / redirect traffic checked against the model
      for (int i = 0; i < 40; i++) begin
         stall       = stall_pat[i];
         imem_ack    = ack_pat[i];
         redirect    = redir_pat[i];
         redirect_pc = 32'h300 + 32'(i) * 8 + 32'(i % 3);
         step();
      end
      redirect = 1'b0;
      stall    = 1'b0;
      imem_ack = 1'b1;
      repeat (4) step();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
